// File: rtl/alias_mon_pkg.sv
// Shared types for the alias net monitor.
//   mon_state_e : monitor FSM states
//   net_mask_t  : one mismatch bit per aliased net, indexed by A_IDX/B_IDX/C_IDX
package alias_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_PASS,
    ST_FAIL
  } mon_state_e;

  typedef logic [2:0] net_mask_t;

  localparam int unsigned A_IDX = 0;
  localparam int unsigned B_IDX = 1;
  localparam int unsigned C_IDX = 2;

endpackage

// File: rtl/alias_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset (count -> 0)
//   i_clr   : synchronous clear (count -> 0), overrides enable
//   i_en    : increment enable; the count holds at all-ones
//   o_cnt   : current count
module alias_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/alias_net_monitor.sv
// Checks a three-way aliased net group (a, b, c) against an expected word.
// A check starts on an accepted start pulse; the monitor then waits for
// STABLE_CYCLES consecutive samples in which all three nets equal the
// captured expected word (pass), or gives up after TIMEOUT samples (fail).
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   start        : begin a check (ignored while busy)
//   expected     : expected word, captured on an accepted start
//   a, b, c      : alias members being monitored
//   busy         : check in progress
//   pass, fail   : sticky result flags
//   mismatch_cnt : saturating count of non-matching samples
//   first_bad    : {c,b,a} at the first mismatching sample
//   first_mask   : per-net mismatch bits at the first mismatching sample
module alias_net_monitor
  import alias_mon_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   expected,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [3*WIDTH-1:0] first_bad,
  output logic [2:0]         first_mask
);

  localparam int unsigned CYC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);

  mon_state_e         r_state;
  mon_state_e         w_next;
  logic [WIDTH-1:0]   r_exp;
  logic [STB_W-1:0]   r_stable;
  logic [CYC_W-1:0]   w_cycle;
  logic [CNT_W-1:0]   w_mcnt;
  logic [3*WIDTH-1:0] r_first_bad;
  net_mask_t          r_first_mask;
  net_mask_t          w_mask;
  logic               w_in_settle;
  logic               w_accept;
  logic               w_match;
  logic               w_pass_done;
  logic               w_timeout;

  assign w_in_settle = (r_state == ST_SETTLE);
  assign w_accept    = start && !w_in_settle;

  // Case inequality so that any X/Z bit on a net registers as a mismatch.
  always_comb begin
    w_mask        = '0;
    w_mask[A_IDX] = (a !== r_exp);
    w_mask[B_IDX] = (b !== r_exp);
    w_mask[C_IDX] = (c !== r_exp);
  end

  assign w_match     = (w_mask == '0);
  assign w_pass_done = w_in_settle && w_match &&
                       (r_stable == STB_W'(STABLE_CYCLES - 1));
  assign w_timeout   = w_in_settle && (w_cycle == CYC_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Pass is checked before timeout so a run completing on the last
  // allowed sample still reports pass.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (w_accept) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_pass_done)    w_next = ST_PASS;
        else if (w_timeout) w_next = ST_FAIL;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exp        <= '0;
      r_stable     <= '0;
      r_first_bad  <= '0;
      r_first_mask <= '0;
    end else if (w_accept) begin
      r_exp        <= expected;
      r_stable     <= '0;
      r_first_bad  <= '0;
      r_first_mask <= '0;
    end else if (w_in_settle) begin
      if (w_match) begin
        r_stable <= r_stable + 1'b1;
      end else begin
        r_stable <= '0;
        // A zero mismatch count means no mismatch has been seen since start.
        if (w_mcnt == '0) begin
          r_first_bad  <= {c, b, a};
          r_first_mask <= w_mask;
        end
      end
    end
  end

  alias_sat_counter #(
    .W (CNT_W)
  ) u_mismatch_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_accept),
    .i_en    (w_in_settle && !w_match),
    .o_cnt   (w_mcnt)
  );

  alias_sat_counter #(
    .W (CYC_W)
  ) u_cycle_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_accept),
    .i_en    (w_in_settle),
    .o_cnt   (w_cycle)
  );

  assign busy         = (r_state == ST_SETTLE);
  assign pass         = (r_state == ST_PASS);
  assign fail         = (r_state == ST_FAIL);
  assign mismatch_cnt = w_mcnt;
  assign first_bad    = r_first_bad;
  assign first_mask   = r_first_mask;

endmodule
